sram_dump_streamer: RTL

- Bulk-read engine between the serial command decoder and `sram_driver`.
- On a `go` pulse it reads `length` consecutive SRAM bytes through the `sram_driver` request/ready handshake, starting at `start_addr`.
- Each byte goes to `uart_tx` as soon as it is read; an optional 8-bit additive checksum byte follows the last data byte.
- This replaces the one-byte-per-command READ_REQ/READ sequence for full-chip dumps.

---
 rtl/sram_dump_streamer_pkg.sv | 30 +++
 rtl/sram_dump_streamer_if.sv | 37 +++
 rtl/sram_dump_streamer_tx.sv | 46 ++++
 rtl/sram_dump_streamer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/sram_dump_streamer_pkg.sv
// Shared definitions for the SRAM dump streamer.
//   - default address / length widths
//   - serial command code for the DUMP command
//   - state encodings for the dump engine and the UART byte sender
package sram_dump_streamer_pkg;

  localparam int DUMP_ADDR_W = 13;
  localparam int DUMP_LEN_W  = 14;  // must hold 2^ADDR_W

  // Serial command code that selects the bulk dump.
  localparam logic [7:0] CMD_DUMP = 8'h08;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAM_REQ,
    S_RAM_SKIP,
    S_RAM_WAIT,
    S_TX,
    S_CSUM,
    S_DONE
  } dump_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_LOW,
    TX_HIGH
  } tx_state_e;

endpackage

// File: rtl/sram_dump_streamer_if.sv
// Bundle of the command, SRAM-driver and UART-tx signals of the dump streamer.
//   master : the streamer (drives busy/done, ram_start/re/address, tx_start/data)
//   slave  : the environment (command decoder, sram_driver, uart_tx)
interface sram_dump_streamer_if
  import sram_dump_streamer_pkg::*;
#(
  parameter int ADDR_W = DUMP_ADDR_W,
  parameter int LEN_W  = DUMP_LEN_W
) ();
  // command side
  logic              go;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  length;
  logic              abort;
  logic              busy;
  logic              done;
  // sram_driver side
  logic              ram_ready;
  logic              ram_start;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_address;
  logic [7:0]        ram_data_read;
  // uart_tx side
  logic              tx_ready;
  logic              tx_start;
  logic [7:0]        tx_data;

  modport master (
    input  go, start_addr, length, abort, ram_ready, ram_data_read, tx_ready,
    output busy, done, ram_start, ram_re, ram_address, tx_start, tx_data
  );

  modport slave (
    output go, start_addr, length, abort, ram_ready, ram_data_read, tx_ready,
    input  busy, done, ram_start, ram_re, ram_address, tx_start, tx_data
  );
endinterface

// File: rtl/sram_dump_streamer_tx.sv
// tx_byte_sender: one-byte handshake with uart_tx.
//   clk_i, reset_i : clock, synchronous active-high reset
//   send_i         : pulse to start sending the byte held on tx_data
//   sent_o         : pulse once uart_tx has gone busy and returned to ready
//   tx_ready_i     : uart_tx ready flag
//   tx_start_o     : one-cycle start strobe to uart_tx
module tx_byte_sender
  import sram_dump_streamer_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic send_i,
  output logic sent_o,
  input  logic tx_ready_i,
  output logic tx_start_o
);

  tx_state_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= TX_IDLE;
    else         state_q <= state_d;
  end

  // uart_tx drops ready up to two cycles after start, so TX_LOW waits for the
  // fall without re-strobing; only then is a rising ready a real completion.
  always_comb begin
    state_d    = state_q;
    tx_start_o = 1'b0;
    sent_o     = 1'b0;
    unique case (state_q)
      TX_IDLE: if (send_i) state_d = TX_REQ;
      TX_REQ:  if (tx_ready_i) begin
                 tx_start_o = 1'b1;
                 state_d    = TX_LOW;
               end
      TX_LOW:  if (!tx_ready_i) state_d = TX_HIGH;
      TX_HIGH: if (tx_ready_i) begin
                 sent_o  = 1'b1;
                 state_d = TX_IDLE;
               end
      default: state_d = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/sram_dump_streamer.sv
// sram_dump_streamer: reads `length` consecutive SRAM bytes from `start_addr`
// through sram_driver and streams each to uart_tx, optionally followed by an
// 8-bit additive checksum of the bytes sent.
//   clk_i, reset_i : clock, synchronous active-high reset
//   bus (master)   : go/start_addr/length/abort/busy/done command handshake,
//                    ram_* sram_driver handshake, tx_* uart_tx handshake
module sram_dump_streamer
  import sram_dump_streamer_pkg::*;
#(
  parameter int ADDR_W   = DUMP_ADDR_W,
  parameter int LEN_W    = DUMP_LEN_W,
  parameter int CHECKSUM = 1
) (
  input  logic           clk_i,
  input  logic           reset_i,
  sram_dump_streamer_if.master bus
);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        csum_q, csum_d;
  logic              abort_q, abort_d;
  logic              csum_ph_q, csum_ph_d;  // the byte in TX is the checksum
  logic              ram_start;
  logic              send, sent;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      csum_q    <= '0;
      abort_q   <= 1'b0;
      csum_ph_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      csum_q    <= csum_d;
      abort_q   <= abort_d;
      csum_ph_q <= csum_ph_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    csum_d    = csum_q;
    csum_ph_d = csum_ph_q;
    abort_d   = abort_q | (bus.abort && state_q != S_IDLE);
    ram_start = 1'b0;
    send      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        abort_d   = 1'b0;
        csum_ph_d = 1'b0;
        if (bus.go) begin
          if (bus.length != '0) begin
            addr_d  = bus.start_addr;
            cnt_d   = bus.length;
            csum_d  = '0;
            state_d = S_RAM_REQ;
          end else begin
            state_d = S_DONE;  // empty dump: just acknowledge
          end
        end
      end
      S_RAM_REQ: if (bus.ram_ready) begin
        ram_start = 1'b1;
        state_d   = S_RAM_SKIP;
      end
      // sram_driver still shows the stale ready flag for one cycle after start
      S_RAM_SKIP: state_d = S_RAM_WAIT;
      S_RAM_WAIT: if (bus.ram_ready) begin
        data_d  = bus.ram_data_read;
        csum_d  = csum_q + bus.ram_data_read;
        send    = 1'b1;
        state_d = S_TX;
      end
      S_TX: if (sent) begin
        if (csum_ph_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          addr_d = addr_q + 1'b1;  // wraps at 2^ADDR_W
          if (cnt_q == LEN_W'(1) || abort_q || bus.abort)
            state_d = (CHECKSUM != 0) ? S_CSUM : S_DONE;
          else
            state_d = S_RAM_REQ;
        end
      end
      S_CSUM: begin
        data_d    = csum_q;
        csum_ph_d = 1'b1;
        send      = 1'b1;
        state_d   = S_TX;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  tx_byte_sender u_tx (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .send_i     (send),
    .sent_o     (sent),
    .tx_ready_i (bus.tx_ready),
    .tx_start_o (bus.tx_start)
  );

  assign bus.busy        = state_q inside {S_RAM_REQ, S_RAM_SKIP, S_RAM_WAIT, S_TX, S_CSUM};
  assign bus.done        = (state_q == S_DONE);
  assign bus.ram_re      = bus.busy;
  assign bus.ram_start   = ram_start;
  assign bus.ram_address = addr_q;
  assign bus.tx_data     = data_q;

endmodule
